// File: rtl/uart_echo_pkg.sv
// Shared encodings for the UART echo engine: transform modes, FSM states
// and the transmitter busy-wait timeout.
package uart_echo_pkg;

  localparam logic [1:0] MODE_ECHO = 2'd0;
  localparam logic [1:0] MODE_INC  = 2'd1;
  localparam logic [1:0] MODE_INV  = 2'd2;
  localparam logic [1:0] MODE_REV  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  localparam int BUSY_TIMEOUT = 255;

endpackage

// File: rtl/uart_echo_engine_echo_fifo.sv
// First-word-fall-through FIFO for the echo engine. A push into a full FIFO
// is still accepted when a pop frees a slot in the same cycle.
module echo_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; reset discards all buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_engine.sv
// UART echo engine: buffers received words, transforms each on pop and
// drives the transmit strobe paced by the UART busy flag.
// Optional statistics counters are built when UART_ECHO_STATS_EN is defined.
module uart_echo_engine
  import uart_echo_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int TX_PULSE_LEN = 3,
  parameter int GAP_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic [1:0]        mode,
  input  logic              clear_ovf,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              debug_led
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [15:0]       rx_words,
  output logic [15:0]       tx_words,
  output logic [7:0]        drop_words
`endif
);

  state_t            state;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              pop;
  logic              push;
  logic              drop;
  logic              gap_done;
  logic [3:0]        pulse_cnt;
  logic [7:0]        busy_tmr;
  logic [15:0]       gap_cnt;

  function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d,
                                              input logic [1:0]        m);
    logic [DATA_W-1:0] r;
    r = d;
    case (m)
      MODE_ECHO: r = d;
      MODE_INC:  r = d + DATA_W'(1);
      MODE_INV:  r = ~d;
      MODE_REV:  for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
      default:   r = d;
    endcase
    return r;
  endfunction

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop      = (state == IDLE) && !empty && !tx_busy;
  assign push     = rx_valid && (!full || pop);
  assign drop     = rx_valid && full && !pop;
  assign gap_done = (({1'b0, gap_cnt} + 17'd1) >= 17'(GAP_CYCLES));

  echo_fifo #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Transmit sequencer: the word is transformed and latched at the pop edge
  // so mode is frozen for the whole word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      debug_led <= 1'b0;
      pulse_cnt <= '0;
      busy_tmr  <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= xform(fifo_dout, mode);
            state   <= LOAD;
          end
        end
        LOAD: begin
          tx_start  <= 1'b1;
          pulse_cnt <= '0;
          state     <= PULSE;
        end
        PULSE: begin
          if (pulse_cnt == 4'(TX_PULSE_LEN - 1)) begin
            tx_start <= 1'b0;
            busy_tmr <= '0;
            state    <= WAIT_BUSY;
          end else begin
            pulse_cnt <= pulse_cnt + 4'd1;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (busy_tmr == 8'(BUSY_TIMEOUT - 1)) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            busy_tmr <= busy_tmr + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            debug_led <= ~debug_led;
            gap_cnt   <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          if (gap_done) state <= IDLE;
          else          gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

`ifdef UART_ECHO_STATS_EN
  // Traffic counters: accepted pushes, completed transmits, saturating drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_words   <= '0;
      tx_words   <= '0;
      drop_words <= '0;
    end else begin
      if (push) rx_words <= rx_words + 16'd1;
      if ((state == WAIT_DONE) && !tx_busy) tx_words <= tx_words + 16'd1;
      if (drop && (drop_words != 8'hFF)) drop_words <= drop_words + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_echo_engine.sv
// Testbench for uart_echo_engine: UART transmitter model, output monitor and
// a queue-based reference model of the expected transmitted words.
module tb_uart_echo_engine;

  localparam int DATA_W       = 8;
  localparam int ADDR_W       = 4;
  localparam int TX_PULSE_LEN = 3;
  localparam int GAP_CYCLES   = 16;
  localparam int BUSY_TO      = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [1:0]        mode;
  logic              clear_ovf;
  logic [ADDR_W:0]   fifo_count;
  logic              overflow;
  logic              debug_led;
`ifdef UART_ECHO_STATS_EN
  logic [15:0]       rx_words;
  logic [15:0]       tx_words;
  logic [7:0]        drop_words;
`endif

  logic busy_model = 1'b0;
  logic busy_force = 1'b0;
  logic uart_en    = 1'b1;
  assign tx_busy = busy_model | busy_force;

  uart_echo_engine #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .TX_PULSE_LEN(TX_PULSE_LEN),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .mode      (mode),
    .clear_ovf (clear_ovf),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .debug_led (debug_led)
`ifdef UART_ECHO_STATS_EN
    ,
    .rx_words  (rx_words),
    .tx_words  (tx_words),
    .drop_words(drop_words)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter for strobe timing
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: records each strobe's word, rise cycle and width
  logic [7:0] got_q[$];
  int         rise_q[$];
  int         cur_w = 0;
  int         last_w = 0;
  logic       start_q = 1'b0;
  always @(negedge clk) begin
    if (tx_start && !start_q) begin
      got_q.push_back(tx_data);
      rise_q.push_back(cyc);
      cur_w = 0;
    end
    if (tx_start) cur_w++;
    else if (start_q) last_w = cur_w;
    start_q = tx_start;
  end

  // UART transmitter model: busy rises 2 cycles after strobe, lasts 10 cycles
  always begin
    @(posedge tx_start);
    if (uart_en) begin
      repeat (2) @(posedge clk);
      #1 busy_model = 1'b1;
      repeat (10) @(posedge clk);
      #1 busy_model = 1'b0;
    end
  end

  // Reference transform from the mode rules, in plain arithmetic
  function automatic logic [7:0] ref_xform(input int m, input logic [7:0] d);
    int v;
    int acc;
    v = int'(d);
    case (m)
      1: return 8'((v + 1) % 256);
      2: return 8'(255 - v);
      3: begin
        acc = 0;
        for (int i = 0; i < 8; i++) acc = acc * 2 + ((v >> i) & 1);
        return 8'(acc);
      end
      default: return d;
    endcase
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (got_q.size() < n) check_val("wait_words_timeout", got_q.size(), n);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, lat, tx_ok, n, m, k;
    logic [7:0] d;
    logic [7:0] exp_q[$];
    int         t_mode[3];
    logic [7:0] t_in[3];
    logic [7:0] t_out[3];
    t_mode = '{1, 2, 3};
    t_in   = '{8'hFF, 8'h0F, 8'h01};
    t_out  = '{8'h00, 8'hF0, 8'h80};

    rx_valid  = 1'b0;
    rx_data   = '0;
    mode      = 2'd0;
    clear_ovf = 1'b0;
    tx_ok     = 0;

    repeat (3) @(negedge clk);
    check_val("rst_tx_data", tx_data, 0);
    check_val("rst_tx_start", tx_start, 0);
    check_val("rst_fifo_count", fifo_count, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_debug_led", debug_led, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Echo path with latency and strobe width
    @(negedge clk);
    rx_data  = 8'h41;
    rx_valid = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (tx_start && lat == 0) lat = i;
    end
    check_val("latency", lat, 3);
    wait_words(1, 100);
    check_val("echo_data", got_q[0], 8'h41);
    check_val("echo_tx_data_held", tx_data, 8'h41);
    check_val("pulse_width", last_w, TX_PULSE_LEN);
    tx_ok = 1;
    check_val("led_after_echo", debug_led, 1);

    // Transform boundaries
    for (int i = 0; i < 3; i++) begin
      mode = 2'(t_mode[i]);
      idx = got_q.size();
      send(t_in[i]);
      wait_words(idx + 1, 200);
      check_val($sformatf("xform_mode%0d", t_mode[i]), got_q[idx], t_out[i]);
      tx_ok++;
    end
    check_val("led_after_xform", debug_led, tx_ok & 1);
    mode = 2'd0;

    // Overflow: 17 words into a 16-deep FIFO with the transmitter stalled
    busy_force = 1'b1;
    idx = got_q.size();
    for (int i = 0; i < 17; i++) send(8'(i));
    @(negedge clk);
    check_val("ovf_count", fifo_count, 16);
    check_val("ovf_flag", overflow, 1);
    busy_force = 1'b0;
    wait_words(idx + 16, 16 * 60);
    for (int i = 0; i < 16; i++) check_val($sformatf("ovf_drain%0d", i), got_q[idx + i], i);
    check_val("ovf_no_17th", got_q.size(), idx + 16);
    check_val("ovf_sticky", overflow, 1);
    tx_ok += 16;
    @(negedge clk);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    check_val("ovf_cleared", overflow, 0);

    // Full FIFO: push lands in the same cycle as the first pop
    busy_force = 1'b1;
    idx = got_q.size();
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i));
    @(negedge clk);
    check_val("full_count", fifo_count, 16);
    @(negedge clk);
    busy_force = 1'b0;
    rx_data    = 8'h30;
    rx_valid   = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check_val("full_pushpop_count", fifo_count, 16);
    check_val("full_pushpop_ovf", overflow, 0);
    wait_words(idx + 17, 17 * 60);
    for (int i = 0; i < 17; i++)
      check_val($sformatf("full_drain%0d", i), got_q[idx + i], 8'h20 + 8'(i));
    tx_ok += 17;

    // Busy timeout: transmitter never acknowledges
    uart_en = 1'b0;
    idx = got_q.size();
    send(8'h55);
    send(8'h66);
    wait_words(idx + 2, 800);
    check_val("to_word0", got_q[idx], 8'h55);
    check_val("to_word1", got_q[idx + 1], 8'h66);
    check_val("to_interval", rise_q[idx + 1] - rise_q[idx],
              TX_PULSE_LEN + BUSY_TO + GAP_CYCLES + 2);
    repeat (400) @(negedge clk);
    check_val("to_no_resend", got_q.size(), idx + 2);
    check_val("to_led_unchanged", debug_led, tx_ok & 1);
    uart_en = 1'b1;

    // Randomised bursts against the reference model
    for (int b = 0; b < 4; b++) begin
      m = $urandom_range(0, 3);
      mode = 2'(m);
      n = $urandom_range(1, 5);
      idx = got_q.size();
      exp_q.delete();
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        exp_q.push_back(ref_xform(m, d));
        send(d);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_words(idx + n, n * 80);
      for (int j = 0; j < n; j++)
        check_val($sformatf("rand_b%0d_w%0d_m%0d", b, j, m), got_q[idx + j], exp_q[j]);
      tx_ok += n;
    end
    check_val("led_after_rand", debug_led, tx_ok & 1);
    mode = 2'd0;

    // Asynchronous reset in the second strobe cycle
    busy_force = 1'b1;
    for (int i = 0; i < 17; i++) send(8'h80 + 8'(i));
    @(negedge clk);
    check_val("rst_pre_ovf", overflow, 1);
    busy_force = 1'b0;
    k = 0;
    while (!tx_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("rst_pre_strobe_seen", tx_start, 1);
    @(posedge clk);
    #1;
    check_val("rst_pre_strobe_2nd", tx_start, 1);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_tx_start", tx_start, 0);
    check_val("rst_mid_count", fifo_count, 0);
    check_val("rst_mid_ovf", overflow, 0);
    check_val("rst_mid_tx_data", tx_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idx = got_q.size();
    repeat (400) @(negedge clk);
    check_val("rst_no_strobe", got_q.size(), idx);
    check_val("rst_post_count", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
